// File: rtl/gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter_pkg.sv
// gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter_pkg: shared FSM state type, default widths and a width helper
package gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, MEAS, FINISH} state_t;
  localparam int CNT_W_DEF       = 16;
  localparam int WIN_W_DEF       = 16;
  localparam int SETTLE_CYC_DEF  = 8;
  localparam int SYNC_STAGES_DEF = 2;
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sync_edge.sv
// gf180mcu_fd_sc_mcu9t5v0__sync_edge: SYNC_STAGES-deep synchronizer with rising-edge pulse
// Ports: CLK/RST clock and sync active-high reset, i_d async input, o_pulse one-cycle rising-edge pulse
module gf180mcu_fd_sc_mcu9t5v0__sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_d,
  output logic o_pulse
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      // truncating the concatenation shifts i_d in at bit 0, valid for any depth >= 1
      r_sync <= SYNC_STAGES'({r_sync, i_d});
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end
  assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;
endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter.sv
// gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter: enables a ring oscillator and counts its rising edges over a CLK window
// Ports: CLK/RST clock and sync active-high reset; START/WINDOW request and window length;
//        RO_IN async oscillator tap; RO_EN oscillator enable; BUSY run in progress;
//        DONE result pulse; COUNT/OVF last result and saturation flag
module gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter
  import gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int WIN_W       = WIN_W_DEF,
  parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIN_W-1:0] WINDOW,
  input  logic             RO_IN,
  output logic             RO_EN,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] COUNT,
  output logic             OVF
);
  localparam int PH_W = max_int(WIN_W, $clog2(SETTLE_CYC + 1));
  state_t           r_state, w_state_nxt;
  logic [PH_W-1:0]  r_phase, w_phase_nxt;
  logic [WIN_W-1:0] r_win, w_win_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, r_count;
  logic             r_acc_ovf, w_acc_ovf_nxt, r_ovf;
  logic             w_pulse;
  gf180mcu_fd_sc_mcu9t5v0__sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK    (CLK),
    .RST    (RST),
    .i_d    (RO_IN),
    .o_pulse(w_pulse)
  );
  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase;
    w_win_nxt     = r_win;
    w_cnt_nxt     = r_cnt;
    w_acc_ovf_nxt = r_acc_ovf;
    case (r_state)
      IDLE: if (START) begin
        // a zero window skips the oscillator entirely and reports an empty result
        w_state_nxt   = (WINDOW != '0) ? SETTLE : FINISH;
        w_phase_nxt   = PH_W'(SETTLE_CYC - 1);
        w_win_nxt     = WINDOW;
        w_cnt_nxt     = '0;
        w_acc_ovf_nxt = 1'b0;
      end
      SETTLE: begin
        w_state_nxt = (r_phase == '0) ? MEAS : SETTLE;
        w_phase_nxt = (r_phase == '0) ? PH_W'(r_win) - PH_W'(1) : r_phase - PH_W'(1);
      end
      MEAS: begin
        // saturate rather than wrap; the sticky flag records the lost edges
        w_cnt_nxt     = (w_pulse && !(&r_cnt)) ? r_cnt + CNT_W'(1) : r_cnt;
        w_acc_ovf_nxt = r_acc_ovf | (w_pulse & (&r_cnt));
        w_state_nxt   = (r_phase == '0) ? FINISH : MEAS;
        w_phase_nxt   = r_phase - PH_W'(1);
      end
      FINISH: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_phase   <= '0;
      r_win     <= '0;
      r_cnt     <= '0;
      r_acc_ovf <= 1'b0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_phase   <= w_phase_nxt;
      r_win     <= w_win_nxt;
      r_cnt     <= w_cnt_nxt;
      r_acc_ovf <= w_acc_ovf_nxt;
      // results load on entry to FINISH so they are already valid while DONE is high
      r_count   <= (w_state_nxt == FINISH) ? w_cnt_nxt : r_count;
      r_ovf     <= (w_state_nxt == FINISH) ? w_acc_ovf_nxt : r_ovf;
    end
  end
  assign RO_EN = (r_state == SETTLE) || (r_state == MEAS);
  assign BUSY  = RO_EN;
  assign DONE  = (r_state == FINISH);
  assign COUNT = r_count;
  assign OVF   = r_ovf;
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter.sv
// tb_gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter: directed scoreboard bench for the ring-oscillator frequency meter
module tb_gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter;
  localparam int S = 8;
  typedef struct {
    int cnt;
    bit ovf;
    int cyc;
  } exp_t;
  logic        CLK = 1'b0, RST = 1'b1, START = 1'b0, START4 = 1'b0, RO_IN = 1'b0;
  logic [15:0] WINDOW = '0;
  logic        ro_en, busy, done, ovf, ro_en4, busy4, done4, ovf4;
  logic [15:0] count;
  logic [3:0]  count4;
  int          cyc = 0, ro_hi = 0, checks = 0, failures = 0;
  int          period = 4, ph = 0, ro_base = 0, c = 0;
  logic        ro_static = 1'b0;
  exp_t        q[$], q4[$];
  gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter dut (
    .CLK(CLK), .RST(RST), .START(START), .WINDOW(WINDOW), .RO_IN(RO_IN),
    .RO_EN(ro_en), .BUSY(busy), .DONE(done), .COUNT(count), .OVF(ovf)
  );
  gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .START(START4), .WINDOW(WINDOW), .RO_IN(RO_IN),
    .RO_EN(ro_en4), .BUSY(busy4), .DONE(done4), .COUNT(count4), .OVF(ovf4)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;
  always @(negedge CLK) if (ro_en) ro_hi++;
  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial forever begin
    @(negedge CLK);
    if (period == 0) RO_IN = ro_static;
    else begin
      ph = (ph + 1) % period;
      RO_IN = (ph < period / 2);
    end
  end
  always @(negedge CLK) if (done) begin
    exp_t e;
    chk("done_expected", q.size() > 0, 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("count", count, e.cnt);
      chk("ovf", ovf, e.ovf);
      chk("done_cycle", cyc, e.cyc);
      chk("busy_at_done", {busy, ro_en}, 0);
    end
  end
  always @(negedge CLK) if (done4) begin
    exp_t e;
    chk("done4_expected", q4.size() > 0, 1);
    if (q4.size() > 0) begin
      e = q4.pop_front();
      chk("count4", count4, e.cnt);
      chk("ovf4", ovf4, e.ovf);
      chk("done4_cycle", cyc, e.cyc);
    end
  end
  task automatic start(input int w, input int ec, input bit eo, input bit four);
    exp_t e;
    @(negedge CLK);
    WINDOW = 16'(w);
    if (four) START4 = 1'b1;
    else START = 1'b1;
    e.cnt = ec;
    e.ovf = eo;
    e.cyc = cyc + 1 + ((w == 0) ? 0 : S + w);
    if (four) q4.push_back(e);
    else q.push_back(e);
    @(negedge CLK);
    START = 1'b0;
    START4 = 1'b0;
  endtask
  task automatic wait_q(input int maxc);
    int i = 0;
    while ((q.size() != 0 || q4.size() != 0) && i < maxc) begin
      @(negedge CLK);
      i++;
    end
    chk("done_timeout", q.size() + q4.size(), 0);
  endtask
  initial begin
    exp_t e;
    repeat (3) @(negedge CLK);
    chk("rst_outputs", {ro_en, busy, done, ovf, count}, 0);
    chk("rst_outputs4", {ro_en4, busy4, done4, ovf4, count4}, 0);
    RST = 1'b0;
    repeat (10) @(negedge CLK);
    ro_base = ro_hi;
    start(100, 25, 0, 0);
    wait_q(200);
    chk("ro_en_cycles", ro_hi - ro_base, 108);
    @(negedge CLK);
    chk("count_hold", count, 25);
    period = 2;
    repeat (10) @(negedge CLK);
    start(64, 15, 1, 1);
    wait_q(200);
    period = 8;
    repeat (10) @(negedge CLK);
    start(64, 8, 0, 1);
    wait_q(200);
    ro_static = 1'b1;
    period = 0;
    repeat (10) @(negedge CLK);
    start(50, 0, 0, 0);
    wait_q(200);
    ro_base = ro_hi;
    start(0, 0, 0, 0);
    wait_q(20);
    chk("zero_window_ro_en", ro_hi - ro_base, 0);
    chk("zero_window_busy", busy, 0);
    period = 4;
    repeat (10) @(negedge CLK);
    start(20, 5, 0, 0);
    repeat (4) @(negedge CLK);
    START = 1'b1;
    WINDOW = 16'd3;
    @(negedge CLK);
    START = 1'b0;
    repeat (9) @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_q(200);
    repeat (10) @(negedge CLK);
    start(100, 0, 0, 0);
    repeat (11) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    q.delete();
    chk("rst_mid_busy", {busy, ro_en, done}, 0);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_ovf", ovf, 0);
    period = 5;
    repeat (10) @(negedge CLK);
    start(10, 2, 0, 0);
    wait_q(100);
    repeat (5) @(negedge CLK);
    WINDOW = 16'd10;
    START = 1'b1;
    c = cyc;
    for (int k = 0; k < 3; k++) begin
      e.cnt = 2;
      e.ovf = 1'b0;
      e.cyc = c + 19 + 20 * k;
      q.push_back(e);
    end
    wait_q(200);
    START = 1'b0;
    repeat (30) @(negedge CLK);
    chk("final_idle", {busy, ro_en}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
